// File: rtl/comparator_search_ctrl.sv
// Lookup engine: scans a DEPTH-entry tag table one entry per cycle through a
// single shared equality comparator and reports the lowest matching index.

module comparator #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   output logic             result
);
   assign result = (in_1 == in_2);
endmodule

module comparator_search_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     clear,
   input  logic                     start,
   input  logic [WIDTH-1:0]         key,
   output logic                     busy,
   output logic                     done,
   output logic                     hit,
   output logic [$clog2(DEPTH)-1:0] hit_index
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SEARCH = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] key_q, key_d;
   logic             hit_q, hit_d;
   logic [AW-1:0]    hit_index_q, hit_index_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [WIDTH-1:0] entry_q [DEPTH];
   logic             cmp_result;
   logic             match;

   // Compare reads the table asynchronously so a same-cycle write is not seen.
   comparator #(.WIDTH(WIDTH)) u_cmp (
      .in_1   (key_q),
      .in_2   (entry_q[idx_q]),
      .result (cmp_result)
   );

   assign match = cmp_result & valid_q[idx_q];

   // Clear drops every valid bit, but a simultaneous write re-validates its entry.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_valid
         assign valid_d[gi] = (wr_en && (wr_addr == AW'(gi))) ? 1'b1 :
                              (clear ? 1'b0 : valid_q[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         entry_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      key_d       = key_q;
      hit_d       = hit_q;
      hit_index_d = hit_index_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d   = key;
               idx_d   = '0;
               state_d = S_SEARCH;
            end
         end
         S_SEARCH: begin
            if (match) begin
               hit_d       = 1'b1;
               hit_index_d = idx_q;
               state_d     = S_DONE;
            end else if (idx_q == AW'(DEPTH - 1)) begin
               hit_d       = 1'b0;
               hit_index_d = '0;
               state_d     = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         key_q       <= '0;
         hit_q       <= 1'b0;
         hit_index_q <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         key_q       <= key_d;
         hit_q       <= hit_d;
         hit_index_q <= hit_index_d;
         valid_q     <= valid_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign hit       = hit_q;
   assign hit_index = hit_index_q;

endmodule

// File: tb/tb_comparator_search_ctrl.sv
// Randomised and directed checks of comparator_search_ctrl against a table-scan
// reference model of the tag table.

module tb_comparator_search_ctrl;
   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [2:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             clear;
   logic             start;
   logic [WIDTH-1:0] key;
   logic             busy;
   logic             done;
   logic             hit;
   logic [2:0]       hit_index;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [WIDTH-1:0] m_data  [DEPTH];
   bit               m_valid [DEPTH];

   comparator_search_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .clear     (clear),
      .start     (start),
      .key       (key),
      .busy      (busy),
      .done      (done),
      .hit       (hit),
      .hit_index (hit_index)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int a, input logic [WIDTH-1:0] d);
      wr_addr = 3'(a);
      wr_data = d;
      wr_en   = 1'b1;
      tick();
      wr_en     = 1'b0;
      m_data[a]  = d;
      m_valid[a] = 1'b1;
   endtask

   task automatic clear_all();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < DEPTH; i++) write_entry(i, 8'(8'h10 + i));
   endtask

   // Reference: lowest valid entry equal to the key; latency in edges after start.
   task automatic ref_search(input logic [WIDTH-1:0] k, output bit h, output int ix,
                             output int lat);
      h = 1'b0; ix = 0; lat = DEPTH;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m_valid[i] && m_data[i] == k) begin
            h = 1'b1; ix = i; lat = i + 1;
         end
      end
   endtask

   task automatic run_search(input logic [WIDTH-1:0] k, output int lat, output int busy_cyc);
      start = 1'b1;
      key   = k;
      tick();
      start    = 1'b0;
      lat      = -1;
      busy_cyc = busy ? 1 : 0;
      for (int n = 1; n <= DEPTH + 4; n++) begin
         tick();
         if (busy) busy_cyc++;
         if (done) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp += 4;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
      if (hit !== 1'b0) begin n_bad++; $display("FAIL reset_hit got=%b exp=0", hit); end
      if (hit_index !== 3'd0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", hit_index); end
      rst = 1'b0;
      tick();
      $display("reset: busy=%b done=%b hit=%b idx=%0d", busy, done, hit, hit_index);
   endtask

   task automatic test_hit_first();
      int lat, bc, elat, eix;
      bit eh;
      clear_all();
      fill_ramp();
      ref_search(8'h13, eh, eix, elat);
      run_search(8'h13, lat, bc);
      n_cmp += 4;
      if (lat != elat) begin n_bad++; $display("FAIL hit3_latency got=%0d exp=%0d", lat, elat); end
      if (hit !== eh) begin n_bad++; $display("FAIL hit3_hit got=%b exp=%b", hit, eh); end
      if (hit_index !== 3'(eix)) begin n_bad++; $display("FAIL hit3_idx got=%0d exp=%0d", hit_index, eix); end
      if (bc != 5) begin n_bad++; $display("FAIL hit3_busy_cycles got=%0d exp=5", bc); end
      tick();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL hit3_single_pulse done=%b busy=%b exp=0/0", done, busy);
      end
      $display("search key=13: lat=%0d hit=%b idx=%0d busy_cycles=%0d", lat, hit, hit_index, bc);
   endtask

   task automatic test_miss();
      int lat, bc;
      run_search(8'h55, lat, bc);
      n_cmp += 3;
      if (lat != DEPTH) begin n_bad++; $display("FAIL miss_latency got=%0d exp=%0d", lat, DEPTH); end
      if (hit !== 1'b0) begin n_bad++; $display("FAIL miss_hit got=%b exp=0", hit); end
      if (hit_index !== 3'd0) begin n_bad++; $display("FAIL miss_idx got=%0d exp=0", hit_index); end
      tick();
      $display("search key=55: lat=%0d hit=%b idx=%0d", lat, hit, hit_index);
   endtask

   task automatic test_multi_and_clear();
      int lat, bc, elat, eix;
      bit eh;
      write_entry(2, 8'h13);
      write_entry(5, 8'h13);
      ref_search(8'h13, eh, eix, elat);
      run_search(8'h13, lat, bc);
      n_cmp += 3;
      if (lat != elat) begin n_bad++; $display("FAIL multi_latency got=%0d exp=%0d", lat, elat); end
      if (hit !== eh) begin n_bad++; $display("FAIL multi_hit got=%b exp=%b", hit, eh); end
      if (hit_index !== 3'(eix)) begin n_bad++; $display("FAIL multi_idx got=%0d exp=%0d", hit_index, eix); end
      tick();
      $display("multi key=13: lat=%0d hit=%b idx=%0d", lat, hit, hit_index);
      clear_all();
      run_search(8'h13, lat, bc);
      n_cmp += 2;
      if (lat != DEPTH) begin n_bad++; $display("FAIL cleared_latency got=%0d exp=%0d", lat, DEPTH); end
      if (hit !== 1'b0) begin n_bad++; $display("FAIL cleared_hit got=%b exp=0", hit); end
      tick();
      $display("after clear key=13: lat=%0d hit=%b", lat, hit);
   endtask

   task automatic test_start_while_busy();
      int lat, ndone, elat, eix;
      bit eh;
      logic got_hit;
      clear_all();
      fill_ramp();
      start = 1'b1;
      key   = 8'h17;
      tick();
      start   = 1'b0;
      ndone   = 0;
      lat     = -1;
      got_hit = 1'bx;
      for (int n = 1; n <= 20; n++) begin
         if (n == 2) start = 1'b1;
         if (n == 3) begin
            start = 1'b0; wr_addr = 3'd7; wr_data = 8'hAA; wr_en = 1'b1;
            m_data[7] = 8'hAA;
         end
         if (n == 4) wr_en = 1'b0;
         tick();
         if (done) begin
            ndone++;
            if (lat < 0) begin lat = n; got_hit = hit; end
         end
      end
      ref_search(8'h17, eh, eix, elat);
      n_cmp += 4;
      if (ndone != 1) begin n_bad++; $display("FAIL busy_start_pulses got=%0d exp=1", ndone); end
      if (lat != elat) begin n_bad++; $display("FAIL busy_start_latency got=%0d exp=%0d", lat, elat); end
      if (got_hit !== eh) begin n_bad++; $display("FAIL busy_start_hit got=%b exp=%b", got_hit, eh); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_queued busy=%b exp=0", busy); end
      $display("start while busy: pulses=%0d lat=%0d hit=%b", ndone, lat, got_hit);
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, bc, t1, t2, e1, e2, eix;
      bit eh;
      ref_search(8'h12, eh, eix, e1);
      run_search(8'h12, lat1, bc);
      t1 = cyc;
      tick();
      ref_search(8'h14, eh, eix, e2);
      run_search(8'h14, lat2, bc);
      t2 = cyc;
      n_cmp += 4;
      if (lat1 != e1) begin n_bad++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat1, e1); end
      if (lat2 != e2) begin n_bad++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, e2); end
      if (t2 - t1 != e2 + 2) begin n_bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", t2 - t1, e2 + 2); end
      if (hit_index !== 3'(eix)) begin n_bad++; $display("FAIL b2b_idx got=%0d exp=%0d", hit_index, eix); end
      tick();
      $display("back to back: lat1=%0d lat2=%0d spacing=%0d idx=%0d", lat1, lat2, t2 - t1, hit_index);
   endtask

   task automatic test_random();
      int lat, bc, elat, eix, nw;
      bit eh;
      logic [WIDTH-1:0] k;
      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 3) == 0) clear_all();
         nw = int'($urandom_range(1, 4));
         for (int w = 0; w < nw; w++) begin
            write_entry(int'($urandom_range(0, DEPTH - 1)), 8'(8'h20 + $urandom_range(0, 3)));
         end
         k = 8'(8'h20 + $urandom_range(0, 4));
         ref_search(k, eh, eix, elat);
         run_search(k, lat, bc);
         n_cmp += 3;
         if (lat != elat) begin n_bad++; $display("FAIL rand_latency it=%0d got=%0d exp=%0d", it, lat, elat); end
         if (hit !== eh) begin n_bad++; $display("FAIL rand_hit it=%0d got=%b exp=%b", it, hit, eh); end
         if (hit_index !== 3'(eix)) begin n_bad++; $display("FAIL rand_idx it=%0d got=%0d exp=%0d", it, hit_index, eix); end
         tick();
         $display("random it=%0d key=%h: lat=%0d hit=%b idx=%0d", it, k, lat, hit, hit_index);
      end
   endtask

   task automatic test_reset_mid_search();
      int lat, bc;
      write_entry(6, 8'h66);
      run_search(8'h66, lat, bc);
      tick();
      n_cmp++;
      if (hit !== 1'b1) begin n_bad++; $display("FAIL pre_reset_hit got=%b exp=1", hit); end
      start = 1'b1;
      key   = 8'h77;
      tick();
      start = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      #2 rst = 1'b1;
      #1;
      n_cmp += 4;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
      if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b exp=0", done); end
      if (hit !== 1'b0) begin n_bad++; $display("FAIL midrst_hit got=%b exp=0", hit); end
      if (hit_index !== 3'd0) begin n_bad++; $display("FAIL midrst_idx got=%0d exp=0", hit_index); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         tick();
         n_cmp++;
         if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_stray_done cycle=%0d got=%b exp=0", n, done); end
      end
      run_search(8'h66, lat, bc);
      n_cmp += 2;
      if (lat != DEPTH) begin n_bad++; $display("FAIL postrst_latency got=%0d exp=%0d", lat, DEPTH); end
      if (hit !== 1'b0) begin n_bad++; $display("FAIL postrst_hit got=%b exp=0", hit); end
      tick();
      $display("reset mid search: post-reset search lat=%0d hit=%b", lat, hit);
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      clear = 1'b0; start = 1'b0; key = '0;
      for (int i = 0; i < DEPTH; i++) begin m_data[i] = '0; m_valid[i] = 1'b0; end
      test_reset();
      test_hit_first();
      test_miss();
      test_multi_and_clear();
      test_start_while_busy();
      test_back_to_back();
      test_random();
      test_reset_mid_search();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/comparator_search_ctrl.md
Name: comparator_search_ctrl

Overview:
- Sequencer that shares one `comparator #(WIDTH)` instance across a DEPTH-entry tag table, searching it one entry per cycle for a key.
- Reports first-match index (lowest index wins) with a hit/miss flag.
- Sits beside the register/tag storage of the microprocessor as the lookup engine feeding the interconnect routing logic.
- The comparator's `result` is 1 iff `in_1 == in_2`.

Parameters:
- WIDTH, 8, bit width of key and table entries.
- DEPTH, 8, number of table entries (≥2, power of two).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write table entry this cycle.
- wr_addr  input  $clog2(DEPTH)  entry written.
- wr_data  input  WIDTH  value written; sets the entry's valid bit.
- clear  input  1  clear all valid bits.
- start  input  1  begin search (accepted only in IDLE).
- key  input  WIDTH  search key, sampled with start.
- busy  output  1  high in SEARCH and DONE.
- done  output  1  one-cycle pulse when result is ready.
- hit  output  1  match found in last search.
- hit_index  output  $clog2(DEPTH)  index of first match; 0 on miss.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - busy=0, done=0, hit=0, hit_index=0.
  - All valid bits=0, idx=0, key_reg=0.
  - Entry data need not be reset.
- Reset asserted mid-search aborts the search immediately; no done pulse is produced.
- FSM IDLE → SEARCH → DONE → IDLE.
  - IDLE: on start=1 at an edge, key_reg←key, idx←0, go to SEARCH. start=0 stays in IDLE.
  - SEARCH:
    - The comparator compares key_reg with entry[idx] every cycle.
    - match = result & valid[idx].
    - If match, at the edge: hit←1, hit_index←idx, go to DONE.
    - Else if idx==DEPTH-1: hit←0, hit_index←0, go to DONE.
    - Else idx←idx+1.
  - DONE: done=1 for exactly this one cycle, then go to IDLE.
- Latency:
  - Match at index i: done is high in the cycle following edge i+1, counted after the edge that sampled start.
  - Miss: done is high in the cycle following edge DEPTH.
  - Back-to-back searches: start may be asserted in the first IDLE cycle after DONE, giving a minimum of 1 idle cycle between done pulses.
- start while busy is ignored; it is not queued.
- hit and hit_index are updated only on entry to DONE and hold until the next search completes.
- Writes:
  - Accepted in any state: entry[wr_addr]←wr_data, valid[wr_addr]←1.
  - The SEARCH compare in a cycle uses pre-edge contents, so a write to entry[idx] in the same cycle is not seen.
- clear:
  - Valid bits←0 at the edge in any state.
  - clear and wr_en in the same cycle: clear applies to all entries, then the write sets valid[wr_addr] (write wins for that entry).
  - A clear during SEARCH makes all subsequent compares miss.
- Invalid entries never match, even if the stored data equals the key.
- Multiple matching entries: the lowest index is reported.
- idx wraps never; the search ends at DEPTH-1.

Test Plan:
- Reset, then write entries 0..7 = 0x10..0x17, start with key=0x13 → done pulses one cycle, 4 edges after start; hit=1, hit_index=3, busy high for 5 cycles.
- key=0x55 (absent) → done at edge 8 after start, hit=0, hit_index=0.
- Write entry 2 = 0x13 and entry 5 = 0x13, search 0x13 → hit=1, hit_index=2. Then clear, search 0x13 → hit=0.
- Start search key=0x17; pulse start again at cycle 2 and write entry 7=0xAA during SEARCH (before idx reaches 7) → second start ignored, single done, hit=0.
- Assert rst while busy (idx=4) → busy/done/hit/hit_index=0 at once, no done pulse, all valid bits 0. A following search of any key misses.
- Start asserted in the IDLE cycle right after a done → second search runs, done pulses separated by the search latency +1.
